// File: rtl/disassembler_if.sv
// rtl/disassembler_if.sv - instruction-in / character-out handshake bundle for the disassembler
interface disassembler_if;
  logic [31:0] instruction;
  logic        new_instruction;
  logic        ready;
  logic [7:0]  outgoing_character;
  logic        new_character;
  logic        char_ready;
  logic        new_line;
  logic        done_flag;
  logic        error_flag;

  modport slave (
    input  instruction, new_instruction, char_ready,
    output ready, outgoing_character, new_character, new_line, done_flag, error_flag
  );

  modport master (
    output instruction, new_instruction, char_ready,
    input  ready, outgoing_character, new_character, new_line, done_flag, error_flag
  );
endinterface

// File: rtl/disassembler.sv
// rtl/disassembler.sv - RV32I word to one ASCII text line, one character per handshake
// Optional macro DISASM_ZERO_SUPPRESS_EN: drop leading zero hex digits of the immediate.
module disassembler #(
  parameter logic [7:0] EOL_CHAR  = 8'h0A,
  parameter bit         HEX_UPPER = 1'b0
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  disassembler_if.slave bus
);
  typedef enum logic [3:0] {IDLE, MNEM, SEP, REG, IMM_PFX, IMM_HEX, EOL, ERR} state_t;
  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J} fmt_t;
  typedef struct packed {
    logic        valid;
    fmt_t        fmt;
    logic [39:0] mnem;
  } dec_t;

  // Mnemonics are right-justified byte strings; an empty string marks an unknown encoding.
  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3     = w[14:12];
    f7     = w[31:25];
    d.fmt  = F_I;
    d.mnem = '0;
    case (w[6:0])
      7'b0110011: begin
        d.fmt = F_R;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: d.mnem = 40'("add");  3'd1: d.mnem = 40'("sll");
            3'd2: d.mnem = 40'("slt");  3'd3: d.mnem = 40'("sltu");
            3'd4: d.mnem = 40'("xor");  3'd5: d.mnem = 40'("srl");
            3'd6: d.mnem = 40'("or");   default: d.mnem = 40'("and");
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'd0) d.mnem = 40'("sub");
        else if (f7 == 7'b0100000 && f3 == 3'd5)     d.mnem = 40'("sra");
      end
      7'b0010011: begin
        case (f3)
          3'd0: d.mnem = 40'("addi");  3'd2: d.mnem = 40'("slti");
          3'd3: d.mnem = 40'("sltiu"); 3'd4: d.mnem = 40'("xori");
          3'd6: d.mnem = 40'("ori");   3'd7: d.mnem = 40'("andi");
          3'd1: if (f7 == 7'b0000000) d.mnem = 40'("slli");
          default: begin
            if (f7 == 7'b0000000)      d.mnem = 40'("srli");
            else if (f7 == 7'b0100000) d.mnem = 40'("srai");
          end
        endcase
      end
      7'b0000011: begin
        case (f3)
          3'd0: d.mnem = 40'("lb");  3'd1: d.mnem = 40'("lh");
          3'd2: d.mnem = 40'("lw");  3'd4: d.mnem = 40'("lbu");
          3'd5: d.mnem = 40'("lhu"); default: ;
        endcase
      end
      7'b0100011: begin
        d.fmt = F_S;
        case (f3)
          3'd0: d.mnem = 40'("sb"); 3'd1: d.mnem = 40'("sh");
          3'd2: d.mnem = 40'("sw"); default: ;
        endcase
      end
      7'b1100011: begin
        d.fmt = F_B;
        case (f3)
          3'd0: d.mnem = 40'("beq");  3'd1: d.mnem = 40'("bne");
          3'd4: d.mnem = 40'("blt");  3'd5: d.mnem = 40'("bge");
          3'd6: d.mnem = 40'("bltu"); 3'd7: d.mnem = 40'("bgeu");
          default: ;
        endcase
      end
      7'b0110111: begin d.fmt = F_U; d.mnem = 40'("lui");   end
      7'b0010111: begin d.fmt = F_U; d.mnem = 40'("auipc"); end
      7'b1101111: begin d.fmt = F_J; d.mnem = 40'("jal");   end
      7'b1100111: if (f3 == 3'd0) d.mnem = 40'("jalr");
      default: ;
    endcase
    d.valid = (d.mnem != '0);
    return d;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'b0, n};
    return (HEX_UPPER ? 8'h41 : 8'h61) + {4'b0, n} - 8'd10;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] inst_q, inst_d;
  logic        done_q;

  dec_t        dq;
  logic [2:0]  mlen, byte_sel, hex_start;
  logic [1:0]  nregs, nops;
  logic [4:0]  rnum, tens, ones;
  logic [31:0] imm;
  logic        reg_last;

  assign dq = decode(inst_q);

  always_comb begin
    mlen = 3'd0;
    for (int i = 0; i < 5; i++) if (dq.mnem[8*i +: 8] != 8'h00) mlen = mlen + 3'd1;
    byte_sel = mlen - 3'd1 - idx_q;
  end

  // Operand slots in print order; the immediate, when present, always follows the registers.
  always_comb begin
    nregs = 2'd2;
    rnum  = inst_q[11:7];
    case (dq.fmt)
      F_R:     begin nregs = 2'd3; rnum = (op_q == 2'd0) ? inst_q[11:7] : (op_q == 2'd1) ? inst_q[19:15] : inst_q[24:20]; end
      F_S:     rnum = (op_q == 2'd0) ? inst_q[24:20] : inst_q[19:15];
      F_B:     rnum = (op_q == 2'd0) ? inst_q[19:15] : inst_q[24:20];
      F_U, F_J: nregs = 2'd1;
      default: rnum = (op_q == 2'd0) ? inst_q[11:7] : inst_q[19:15];
    endcase
    nops = (dq.fmt == F_R) ? 2'd3 : nregs + 2'd1;
    tens = (rnum >= 5'd30) ? 5'd3 : (rnum >= 5'd20) ? 5'd2 : (rnum >= 5'd10) ? 5'd1 : 5'd0;
    ones = rnum - tens * 5'd10;
    reg_last = (idx_q == 3'd2) || (idx_q == 3'd1 && rnum < 5'd10);
  end

  always_comb begin
    case (dq.fmt)
      F_S:     imm = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      F_B:     imm = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      F_J:     imm = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      F_U:     imm = {12'b0, inst_q[31:12]};
      default: imm = (inst_q[6:0] == 7'b0010011 && inst_q[13:12] == 2'b01) ?
                     {27'b0, inst_q[24:20]} : {{20{inst_q[31]}}, inst_q[31:20]};
    endcase
`ifdef DISASM_ZERO_SUPPRESS_EN
    hex_start = 3'd0;
    for (int i = 1; i < 8; i++) if (imm[4*i +: 4] != 4'h0) hex_start = 3'(i);
`else
    hex_start = 3'd7;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      inst_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      inst_q  <= inst_d;
      done_q  <= (state_q == EOL) && bus.char_ready;
    end
  end

  always_comb begin
    state_d                = state_q;
    idx_d                  = idx_q;
    op_d                   = op_q;
    inst_d                 = inst_q;
    bus.outgoing_character = 8'h00;
    bus.new_character      = 1'b0;
    bus.new_line           = 1'b0;
    case (state_q)
      IDLE: if (bus.new_instruction) begin
        inst_d  = bus.instruction;
        idx_d   = '0;
        op_d    = '0;
        state_d = decode(bus.instruction).valid ? MNEM : ERR;
      end
      MNEM: begin
        bus.new_character      = 1'b1;
        bus.outgoing_character = dq.mnem[8*byte_sel +: 8];
        if (bus.char_ready) begin
          if (idx_q == mlen - 3'd1) begin state_d = SEP; idx_d = '0; end
          else idx_d = idx_q + 3'd1;
        end
      end
      SEP: begin
        bus.new_character      = 1'b1;
        bus.outgoing_character = (op_q != 2'd0 && idx_q == 3'd0) ? 8'h2C : 8'h20;
        if (bus.char_ready) begin
          if (op_q == 2'd0 || idx_q == 3'd1) begin
            idx_d   = '0;
            state_d = (op_q < nregs) ? REG : IMM_PFX;
          end else idx_d = idx_q + 3'd1;
        end
      end
      REG: begin
        bus.new_character      = 1'b1;
        bus.outgoing_character = (idx_q == 3'd0) ? 8'h78 :
                                 (idx_q == 3'd1 && rnum >= 5'd10) ? 8'h30 + {3'b0, tens} : 8'h30 + {3'b0, ones};
        if (bus.char_ready) begin
          if (reg_last) begin
            idx_d   = '0;
            op_d    = op_q + 2'd1;
            state_d = (op_q + 2'd1 < nops) ? SEP : EOL;
          end else idx_d = idx_q + 3'd1;
        end
      end
      IMM_PFX: begin
        bus.new_character      = 1'b1;
        bus.outgoing_character = (idx_q == 3'd0) ? 8'h30 : 8'h78;
        if (bus.char_ready) begin
          if (idx_q == 3'd1) begin state_d = IMM_HEX; idx_d = hex_start; end
          else idx_d = idx_q + 3'd1;
        end
      end
      IMM_HEX: begin
        bus.new_character      = 1'b1;
        bus.outgoing_character = hex_char(imm[4*idx_q +: 4]);
        if (bus.char_ready) begin
          if (idx_q == 3'd0) state_d = EOL;
          else idx_d = idx_q - 3'd1;
        end
      end
      EOL: begin
        bus.new_character      = 1'b1;
        bus.new_line           = 1'b1;
        bus.outgoing_character = EOL_CHAR;
        if (bus.char_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.error_flag = (state_q == ERR);
  assign bus.done_flag  = done_q;
endmodule

// File: doc/disassembler.md
DISASSEMBLER -- requirements
Module: disassembler

Interface
REQ-001 SHALL have parameter EOL_CHAR, default 8'h0A: the line terminator character emitted last on every line.
REQ-002 SHALL have parameter HEX_UPPER, default 0: 1 selects uppercase a-f hex digits.
REQ-003 SHALL have clk_in, input, 1: the single clock. The block has one clock; reset is asynchronous and active-low.
REQ-004 SHALL have rst_n_in, input, 1: asynchronous active-low reset.
REQ-005 SHALL have instruction, input, 32: the RV32I machine word to disassemble.
REQ-006 SHALL have new_instruction, input, 1: instruction valid; accepted only when ready is high.
REQ-007 SHALL have ready, output, 1: high only in IDLE.
REQ-008 SHALL have outgoing_character, output, 8: ASCII character being offered.
REQ-009 SHALL have new_character, output, 1: outgoing_character valid.
REQ-010 SHALL have char_ready, input, 1: consumer accepts a character when both new_character and char_ready are high.
REQ-011 SHALL have new_line, output, 1: high together with new_character while EOL_CHAR is offered.
REQ-012 SHALL have done_flag, output, 1: one-cycle pulse in the cycle after EOL_CHAR is transferred.
REQ-013 SHALL have error_flag, output, 1: one-cycle pulse on an undecodable word.

Function
REQ-014 SHALL use FSM states IDLE, MNEM, SEP, REG, IMM_PFX, IMM_HEX, EOL and ERR.
REQ-015 SHALL capture instruction into an internal register when new_instruction and ready are both high, then go to MNEM, or to ERR if the word is undecodable; first character valid the next cycle.
REQ-016 SHALL advance one character per transfer; while new_character is high and char_ready is low, outgoing_character and new_line SHALL stay stable.
REQ-017 SHALL ignore new_instruction while busy; the captured word SHALL NOT change until the next IDLE acceptance.
REQ-018 SHALL emit mnemonics in lowercase: add sub sll slt sltu xor srl sra or and; addi slti sltiu xori ori andi slli srli srai; lb lh lw lbu lhu; sb sh sw; beq bne blt bge bltu bgeu; lui auipc jal jalr.
REQ-019 SHALL emit one space after the mnemonic and ", " between operands.
REQ-020 SHALL use this operand order: REG rd,rs1,rs2; IMM/LOAD/JALR rd,rs1,imm; STORE rs2,rs1,imm; BRANCH rs1,rs2,imm; LUI/AUIPC rd,imm; JAL rd,imm.
REQ-021 SHALL print a register as "x" followed by its decimal number with no leading zero (x0..x31), 2 or 3 characters.
REQ-022 SHALL form the immediate as follows, then print it as "0x" plus hex digits:
- I-type: sign-extended imm[11:0].
- Shifts: shamt only (funct7 dropped).
- S-type: sign-extended {inst[31:25],inst[11:7]}.
- B-type: sign-extended 13-bit byte offset.
- J-type: sign-extended 21-bit byte offset.
- LUI/AUIPC: inst[31:12] zero-extended.
REQ-023 SHALL treat as undecodable any unknown opcode, any unknown funct3/funct7 combination, and any non-zero shift funct7 other than 0100000 on SRAI/SRA/SUB.
REQ-024 SHALL handle an undecodable word in ERR: error_flag pulses for one cycle, no character is emitted, and the block returns to IDLE the next cycle.
REQ-025 SHALL, after the EOL_CHAR transfer, pulse done_flag for one cycle in IDLE.

Reset
REQ-026 SHALL, while rst_n_in is low, asynchronously force:
- state IDLE, ready=1;
- new_character=0, new_line=0, done_flag=0, error_flag=0;
- outgoing_character=8'h00, captured word=0.
REQ-027 SHALL abandon a line in progress on reset with no terminator; the first acceptance after reset release starts a fresh line.

Configuration
REQ-028 SHALL implement leading-zero suppression under macro DISASM_ZERO_SUPPRESS_EN.
- Defined: hex digits omit leading zeros, minimum one digit ("0x0", "0x8", "0xfffffff0").
- Undefined: exactly 8 hex digits always.

Verification
REQ-029 SHALL cover: 0x003100B3, char_ready=1 -> "add x1, x2, x3" then 0x0A; 15 transfers; new_line on the last; done_flag the next cycle.
REQ-030 SHALL cover: 0xFFF00293 -> "addi x5, x0, 0xffffffff\n", both with and without the macro.
REQ-031 SHALL cover: 0x01F12423 -> "sw x31, x2, 0x00000008\n" without the macro; "sw x31, x2, 0x8\n" with it.
REQ-032 SHALL cover: char_ready low for 5 cycles on the 3rd character -> character stable; no skip or duplicate; full line intact.
REQ-033 SHALL cover: 0xFFFFFFFF -> error_flag one cycle, new_character never high, ready high 2 cycles after acceptance.
REQ-034 SHALL cover: rst_n_in low mid-line -> outputs reach their reset values without a clock edge; next word 0x000000EF -> "jal x1, 0x00000000\n".
